forwarding_hazard_unit: RTL and testbench
=========================================

// Module: forwarding_hazard_unit
// PURPOSE
// Parametrised forwarding and hazard unit for the 5-stage RV32 core. Sits beside the EX stage.
// Selects each EX source operand from MEM, WB, a registered WB-history bypass, or the regfile value.
// Detects load-use hazards in ID and holds IF/ID for LOAD_BUBBLES cycles while inserting EX bubbles.
// Freezes the whole pipeline while the synchronous data memory reports busy.
// PARAMETERS
// XLEN          32  operand/data width
// NUM_RS        2   source operands per instruction (2 for R/I/S/B; 3 reserved for R4 ops)
// LOAD_BUBBLES  1   bubbles per load-use hazard (1..3); 1 matches a sync DMEM returning data in WB
// REG_AW        5   register address width
// PORTS
// i_clk            in   1             clock, rising edge
// i_rst            in   1             synchronous reset, active high
// i_ID_rs          in   NUM_RS*REG_AW ID-stage source regs, operand k at [k*REG_AW +: REG_AW]
// i_ID_rsUsed      in   NUM_RS        ID operand k actually read
// i_EX_rs          in   NUM_RS*REG_AW EX-stage source regs
// i_EX_rsValue     in   NUM_RS*XLEN   EX-stage regfile values (from ID/EX register)
// i_EX_rd          in   REG_AW        EX destination
// i_EX_MemRead     in   1             EX instruction is a load
// i_MEM_rd         in   REG_AW        MEM destination
// i_MEM_RegWrite   in   1             MEM writes rd
// i_MEM_MemRead    in   1             MEM instruction is a load (result not yet valid)
// i_MEM_value      in   XLEN          MEM ALU result
// i_WB_rd          in   REG_AW        WB destination
// i_WB_RegWrite    in   1             WB writes rd
// i_WB_value       in   XLEN          WB writeback value (ALU or load data)
// i_DMEM_busy      in   1             data memory not ready; whole pipeline must hold
// o_ForwardedValue out  NUM_RS*XLEN   resolved EX operands
// o_ForwardSel     out  NUM_RS*2      per operand: 0 regfile, 1 MEM, 2 WB, 3 WB-history
// o_StallIFID      out  1             hold PC and IF/ID register
// o_BubbleEX       out  1             load NOP into ID/EX
// o_Freeze         out  1             hold all pipeline registers (equals i_DMEM_busy)
// o_StallCount     out  32            saturating count of load-use stall cycles
// BEHAVIOUR
// - Forwarding is combinational. Per operand k, the first match in this order wins:
//   1. MEM: i_MEM_RegWrite & !i_MEM_MemRead & rd==rs
//   2. WB: i_WB_RegWrite & rd==rs
//   3. WB-history: hist_valid & hist_rd==rs
//   4. otherwise regfile
// - rs==x0 always selects the regfile (value 0). No source with rd==0 ever matches.
// - WB-history register covers the regfile's same-edge write/read:
//   - {hist_valid, hist_rd, hist_value} <= {i_WB_RegWrite & rd!=0, i_WB_rd, i_WB_value} each edge.
//   - It is not updated while o_Freeze is high.
// - Load-use detect, combinational: hit = i_EX_MemRead & i_EX_rd!=0 & (any k: i_ID_rsUsed[k] & i_ID_rs[k]==i_EX_rd).
// - FSM RUN/STALL; cnt is a 2-bit counter.
//   - In RUN, hit:
//     - Assert o_StallIFID and o_BubbleEX in the same cycle.
//     - If LOAD_BUBBLES>1: next state STALL, cnt<=LOAD_BUBBLES-2. Else stay in RUN.
//   - In STALL: assert o_StallIFID and o_BubbleEX. If cnt==0 go to RUN, else decrement cnt.
//   - Freeze has priority: while i_DMEM_busy, o_BubbleEX=0, o_StallIFID=0, and state, cnt and o_StallCount hold.
//     hit is still evaluated after the freeze releases.
// - o_StallCount increments on each unfrozen cycle with o_StallIFID=1 and saturates at 2^32-1.
// - Reset, next edge:
//   - state RUN, cnt 0, hist_valid 0, o_StallCount 0.
//   - o_StallIFID and o_BubbleEX are 0 unless a new hit is present.
//   - Reset during STALL aborts the stall.
// - Parameter legality: LOAD_BUBBLES outside 1..3 or NUM_RS outside 1..3 causes an elaboration $error.
// TESTING
// 1. MEM rd=5 val=0x11, WB rd=5 val=0x22, EX rs1=5 -> rs1 gets 0x11, sel=1.
// 2. WB rd=7 val=0xAB on cycle n, EX rs2=7 on n+1, regfile stale 0 -> rs2 0xAB, sel=3.
// 3. EX lw x3, ID add x4,x3,x3 -> one stall+bubble cycle, then WB forward of load data. Repeat with LOAD_BUBBLES=3: exactly 3 cycles.
// 4. rs1=x0 while MEM/WB write rd=0 with val 0xFFFF -> rs1 gets 0, sel=0.
// 5. Load-use hit, then i_DMEM_busy for 4 cycles mid-stall -> o_Freeze=1 for 4 cycles, stall resumes, o_StallCount +LOAD_BUBBLES only.
// 6. i_rst during STALL (LOAD_BUBBLES=3, cnt=1) -> next cycle RUN, stall low, count 0, hist_valid 0.

Source files
------------

// File: rtl/forwarding_hazard_unit_if.sv
// ----------------------------------------------------------------------------
// forwarding_hazard_unit_if
//   Bundles the pipeline-side signals of the forwarding/hazard unit.
//   master : pipeline side (drives i_* stage information, consumes o_*)
//   slave  : forwarding_hazard_unit (consumes i_*, drives o_*)
//   Operand k of a packed per-operand field sits at [k*W +: W].
//   i_ID_rs / i_ID_rsUsed       : ID-stage source regs and "operand read" flags
//   i_EX_rs / i_EX_rsValue      : EX-stage source regs and their regfile values
//   i_EX_rd / i_EX_MemRead      : EX destination, EX is a load
//   i_MEM_*                     : MEM destination, write enable, load flag, ALU result
//   i_WB_*                      : WB destination, write enable, writeback value
//   i_DMEM_busy                 : data memory stall request
//   o_ForwardedValue/o_ForwardSel : resolved EX operands and their source
//   o_StallIFID/o_BubbleEX/o_Freeze/o_StallCount : pipeline control + statistics
// ----------------------------------------------------------------------------
interface forwarding_hazard_unit_if #(
    parameter int XLEN   = 32,
    parameter int NUM_RS = 2,
    parameter int REG_AW = 5
);
    logic [NUM_RS*REG_AW-1:0] i_ID_rs;
    logic [NUM_RS-1:0]        i_ID_rsUsed;
    logic [NUM_RS*REG_AW-1:0] i_EX_rs;
    logic [NUM_RS*XLEN-1:0]   i_EX_rsValue;
    logic [REG_AW-1:0]        i_EX_rd;
    logic                     i_EX_MemRead;
    logic [REG_AW-1:0]        i_MEM_rd;
    logic                     i_MEM_RegWrite;
    logic                     i_MEM_MemRead;
    logic [XLEN-1:0]          i_MEM_value;
    logic [REG_AW-1:0]        i_WB_rd;
    logic                     i_WB_RegWrite;
    logic [XLEN-1:0]          i_WB_value;
    logic                     i_DMEM_busy;

    logic [NUM_RS*XLEN-1:0]   o_ForwardedValue;
    logic [NUM_RS*2-1:0]      o_ForwardSel;
    logic                     o_StallIFID;
    logic                     o_BubbleEX;
    logic                     o_Freeze;
    logic [31:0]              o_StallCount;

    modport master (
        output i_ID_rs, i_ID_rsUsed, i_EX_rs, i_EX_rsValue, i_EX_rd, i_EX_MemRead,
               i_MEM_rd, i_MEM_RegWrite, i_MEM_MemRead, i_MEM_value,
               i_WB_rd, i_WB_RegWrite, i_WB_value, i_DMEM_busy,
        input  o_ForwardedValue, o_ForwardSel, o_StallIFID, o_BubbleEX,
               o_Freeze, o_StallCount
    );

    modport slave (
        input  i_ID_rs, i_ID_rsUsed, i_EX_rs, i_EX_rsValue, i_EX_rd, i_EX_MemRead,
               i_MEM_rd, i_MEM_RegWrite, i_MEM_MemRead, i_MEM_value,
               i_WB_rd, i_WB_RegWrite, i_WB_value, i_DMEM_busy,
        output o_ForwardedValue, o_ForwardSel, o_StallIFID, o_BubbleEX,
               o_Freeze, o_StallCount
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// ----------------------------------------------------------------------------
// forwarding_hazard_unit
//   Operand forwarding and hazard control for the 5-stage RV32 core, placed
//   beside the EX stage.
//   - Each EX operand is taken from MEM, WB, a one-entry WB-history register
//     or the regfile value, first match in that order; x0 always reads 0.
//   - A load in EX feeding an operand read in ID holds IF/ID and bubbles EX
//     for LOAD_BUBBLES cycles.
//   - While the data memory is busy the whole pipeline is frozen.
//   Ports:
//     i_clk  : clock, rising edge
//     i_rst  : synchronous reset, active high
//     bus    : forwarding_hazard_unit_if.slave (stage inputs, control outputs)
// ----------------------------------------------------------------------------
module forwarding_hazard_unit #(
    parameter int XLEN         = 32,
    parameter int NUM_RS       = 2,
    parameter int LOAD_BUBBLES = 1,
    parameter int REG_AW       = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    forwarding_hazard_unit_if.slave bus
);

    if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 3) begin : g_bad_load_bubbles
        $error("forwarding_hazard_unit: LOAD_BUBBLES=%0d outside 1..3", LOAD_BUBBLES);
    end
    if (NUM_RS < 1 || NUM_RS > 3) begin : g_bad_num_rs
        $error("forwarding_hazard_unit: NUM_RS=%0d outside 1..3", NUM_RS);
    end

    typedef enum logic [1:0] {
        SEL_RF   = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_WB   = 2'd2,
        SEL_HIST = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_e;

    state_e             state;
    state_e             state_next;
    logic [1:0]         cnt;
    logic [1:0]         cnt_next;
    logic               hist_valid;
    logic [REG_AW-1:0]  hist_rd;
    logic [XLEN-1:0]    hist_value;
    logic [31:0]        stall_count;
    logic               freeze;
    logic               stall;
    logic               load_use_hit;
    logic [NUM_RS-1:0]  id_match;

    assign freeze = bus.i_DMEM_busy;

    // ------------------------------------------------------------------
    // Per-operand forwarding mux and ID-side load-use comparison
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RS; k++) begin : g_op
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] id_rs;
        logic [XLEN-1:0]   rf_value;
        logic              mem_hit;
        logic              wb_hit;
        logic              hist_hit;
        fwd_sel_e          sel;
        logic [XLEN-1:0]   value;

        assign rs       = bus.i_EX_rs[k*REG_AW +: REG_AW];
        assign id_rs    = bus.i_ID_rs[k*REG_AW +: REG_AW];
        assign rf_value = bus.i_EX_rsValue[k*XLEN +: XLEN];

        // A load still in MEM has no data yet, so it never forwards.
        assign mem_hit  = bus.i_MEM_RegWrite && !bus.i_MEM_MemRead && (bus.i_MEM_rd == rs);
        assign wb_hit   = bus.i_WB_RegWrite && (bus.i_WB_rd == rs);
        assign hist_hit = hist_valid && (hist_rd == rs);

        always_comb begin
            sel   = SEL_RF;
            value = rf_value;
            // rs==x0 short-circuits every match, so rd==0 writers never forward.
            if (rs == '0) begin
                sel   = SEL_RF;
                value = '0;
            end else if (mem_hit) begin
                sel   = SEL_MEM;
                value = bus.i_MEM_value;
            end else if (wb_hit) begin
                sel   = SEL_WB;
                value = bus.i_WB_value;
            end else if (hist_hit) begin
                sel   = SEL_HIST;
                value = hist_value;
            end
        end

        assign bus.o_ForwardedValue[k*XLEN +: XLEN] = value;
        assign bus.o_ForwardSel[k*2 +: 2]           = sel;
        assign id_match[k] = bus.i_ID_rsUsed[k] && (id_rs == bus.i_EX_rd);
    end

    assign load_use_hit = bus.i_EX_MemRead && (bus.i_EX_rd != '0) && (|id_match);

    // ------------------------------------------------------------------
    // Load-use stall FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        // Freeze outranks everything: no control pulses, no state motion.
        if (!freeze) begin
            case (state)
                ST_RUN: begin
                    if (load_use_hit) begin
                        stall = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_next = ST_STALL;
                            cnt_next   = 2'(LOAD_BUBBLES - 2);
                        end
                    end
                end
                ST_STALL: begin
                    stall = 1'b1;
                    if (cnt == '0) begin
                        state_next = ST_RUN;
                    end else begin
                        cnt_next = cnt - 2'd1;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            hist_valid  <= 1'b0;
            hist_rd     <= '0;
            hist_value  <= '0;
            stall_count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (!freeze) begin
                // Mirrors this edge's regfile write, which the ID/EX value read
                // in the same edge could not yet see.
                hist_valid <= bus.i_WB_RegWrite && (bus.i_WB_rd != '0);
                hist_rd    <= bus.i_WB_rd;
                hist_value <= bus.i_WB_value;
                if (stall && (stall_count != '1)) begin
                    stall_count <= stall_count + 32'd1;
                end
            end
        end
    end

    assign bus.o_StallIFID  = stall;
    assign bus.o_BubbleEX   = stall;
    assign bus.o_Freeze     = freeze;
    assign bus.o_StallCount = stall_count;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_forwarding_hazard_unit
//   Drives identical stage inputs into two units (LOAD_BUBBLES=1 and 3).
//   Each directed vector pushes its expected response into a queue; a monitor
//   on the falling edge pops and compares against both units.
// ----------------------------------------------------------------------------
module tb_forwarding_hazard_unit;
    localparam int XLEN   = 32;
    localparam int NUM_RS = 2;
    localparam int REG_AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    forwarding_hazard_unit_if #(.XLEN(XLEN), .NUM_RS(NUM_RS), .REG_AW(REG_AW)) b1 ();
    forwarding_hazard_unit_if #(.XLEN(XLEN), .NUM_RS(NUM_RS), .REG_AW(REG_AW)) b3 ();

    forwarding_hazard_unit #(
        .XLEN(XLEN), .NUM_RS(NUM_RS), .LOAD_BUBBLES(1), .REG_AW(REG_AW)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(b1.slave)
    );

    forwarding_hazard_unit #(
        .XLEN(XLEN), .NUM_RS(NUM_RS), .LOAD_BUBBLES(3), .REG_AW(REG_AW)
    ) dut3 (
        .i_clk(clk), .i_rst(rst), .bus(b3.slave)
    );

    assign b3.i_ID_rs        = b1.i_ID_rs;
    assign b3.i_ID_rsUsed    = b1.i_ID_rsUsed;
    assign b3.i_EX_rs        = b1.i_EX_rs;
    assign b3.i_EX_rsValue   = b1.i_EX_rsValue;
    assign b3.i_EX_rd        = b1.i_EX_rd;
    assign b3.i_EX_MemRead   = b1.i_EX_MemRead;
    assign b3.i_MEM_rd       = b1.i_MEM_rd;
    assign b3.i_MEM_RegWrite = b1.i_MEM_RegWrite;
    assign b3.i_MEM_MemRead  = b1.i_MEM_MemRead;
    assign b3.i_MEM_value    = b1.i_MEM_value;
    assign b3.i_WB_rd        = b1.i_WB_rd;
    assign b3.i_WB_RegWrite  = b1.i_WB_RegWrite;
    assign b3.i_WB_value     = b1.i_WB_value;
    assign b3.i_DMEM_busy    = b1.i_DMEM_busy;

    typedef struct {
        int          tid;
        bit          chk_fwd;
        logic [63:0] fv;
        logic [3:0]  sel;
        logic        st1;
        logic        st3;
        logic        frz;
        logic [31:0] c1;
        logic [31:0] c3;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input int tid, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL t%0d %s actual=0x%0h required=0x%0h", tid, name, act, req);
        end
    endtask

    task automatic push(input int tid, input bit chk_fwd,
                        input logic [63:0] fv, input logic [3:0] sel,
                        input logic st1, input logic st3, input logic frz,
                        input logic [31:0] c1, input logic [31:0] c3);
        exp_t e;
        e.tid     = tid;
        e.chk_fwd = chk_fwd;
        e.fv      = fv;
        e.sel     = sel;
        e.st1     = st1;
        e.st3     = st3;
        e.frz     = frz;
        e.c1      = c1;
        e.c3      = c3;
        exp_q.push_back(e);
    endtask

    // Monitor: the unit is purely per-cycle, so every queued entry is
    // compared on the falling edge of the cycle it was issued in.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.chk_fwd) begin
                check(cur.tid, "fwd_value_lb1", 64'(b1.o_ForwardedValue), cur.fv);
                check(cur.tid, "fwd_sel_lb1",   64'(b1.o_ForwardSel),     64'(cur.sel));
                check(cur.tid, "fwd_value_lb3", 64'(b3.o_ForwardedValue), cur.fv);
                check(cur.tid, "fwd_sel_lb3",   64'(b3.o_ForwardSel),     64'(cur.sel));
            end
            check(cur.tid, "stall_lb1",  64'(b1.o_StallIFID),  64'(cur.st1));
            check(cur.tid, "bubble_lb1", 64'(b1.o_BubbleEX),   64'(cur.st1));
            check(cur.tid, "stall_lb3",  64'(b3.o_StallIFID),  64'(cur.st3));
            check(cur.tid, "bubble_lb3", 64'(b3.o_BubbleEX),   64'(cur.st3));
            check(cur.tid, "freeze_lb1", 64'(b1.o_Freeze),     64'(cur.frz));
            check(cur.tid, "freeze_lb3", 64'(b3.o_Freeze),     64'(cur.frz));
            check(cur.tid, "count_lb1",  64'(b1.o_StallCount), 64'(cur.c1));
            check(cur.tid, "count_lb3",  64'(b3.o_StallCount), 64'(cur.c3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b1.i_ID_rs        = '0;
        b1.i_ID_rsUsed    = '0;
        b1.i_EX_rs        = '0;
        b1.i_EX_rsValue   = '0;
        b1.i_EX_rd        = '0;
        b1.i_EX_MemRead   = 1'b0;
        b1.i_MEM_rd       = '0;
        b1.i_MEM_RegWrite = 1'b0;
        b1.i_MEM_MemRead  = 1'b0;
        b1.i_MEM_value    = '0;
        b1.i_WB_rd        = '0;
        b1.i_WB_RegWrite  = 1'b0;
        b1.i_WB_value     = '0;
        b1.i_DMEM_busy    = 1'b0;
    endtask

    task automatic set_ex(input logic [4:0] rs0, input logic [31:0] v0,
                          input logic [4:0] rs1, input logic [31:0] v1);
        b1.i_EX_rs      = {rs1, rs0};
        b1.i_EX_rsValue = {v1, v0};
    endtask

    task automatic set_mem(input logic we, input logic ld,
                           input logic [4:0] rd, input logic [31:0] v);
        b1.i_MEM_RegWrite = we;
        b1.i_MEM_MemRead  = ld;
        b1.i_MEM_rd       = rd;
        b1.i_MEM_value    = v;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] v);
        b1.i_WB_RegWrite = we;
        b1.i_WB_rd       = rd;
        b1.i_WB_value    = v;
    endtask

    task automatic set_load(input logic ld, input logic [4:0] ex_rd,
                            input logic [4:0] id0, input logic [4:0] id1,
                            input logic [1:0] used);
        b1.i_EX_MemRead = ld;
        b1.i_EX_rd      = ex_rd;
        b1.i_ID_rs      = {id1, id0};
        b1.i_ID_rsUsed  = used;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state with idle inputs
        push(0, 1'b1, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // MEM beats WB for the same rd
        set_mem(1'b1, 1'b0, 5'd5, 32'h11);
        set_wb(1'b1, 5'd5, 32'h22);
        set_ex(5'd5, 32'h55, 5'd6, 32'h66);
        push(1, 1'b1, {32'h66, 32'h11}, 4'b0001, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // MEM is a load: falls through to WB
        set_mem(1'b1, 1'b1, 5'd5, 32'h11);
        push(2, 1'b1, {32'h66, 32'h22}, 4'b0010, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // WB writes x7; op0 x5 comes from history of the previous WB
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 5'd7, 32'hAB);
        set_ex(5'd5, 32'h0, 5'd9, 32'h99);
        push(3, 1'b1, {32'h99, 32'h22}, 4'b0011, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Next cycle: x7 stale in regfile, served by WB history
        set_wb(1'b0, 5'd0, 32'h0);
        set_ex(5'd5, 32'h55, 5'd7, 32'h0);
        push(4, 1'b1, {32'hAB, 32'h55}, 4'b1100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // x0 never forwards even when MEM/WB write rd=0
        set_mem(1'b1, 1'b0, 5'd0, 32'hFFFF);
        set_wb(1'b1, 5'd0, 32'hFFFF);
        set_ex(5'd0, 32'h0, 5'd7, 32'h77);
        push(5, 1'b1, {32'h77, 32'h0}, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Load-use: lw x3 in EX, add x4,x3,x3 in ID
        clear_inputs();
        set_load(1'b1, 5'd3, 5'd3, 5'd3, 2'b11);
        push(10, 1'b0, 64'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        set_load(1'b0, 5'd0, 5'd3, 5'd3, 2'b11);
        set_mem(1'b1, 1'b1, 5'd3, 32'h0);
        push(11, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1);
        tick();
        set_load(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 5'd3, 32'hDEADBEEF);
        set_ex(5'd3, 32'h0, 5'd3, 32'h0);
        push(12, 1'b1, {32'hDEADBEEF, 32'hDEADBEEF}, 4'b1010,
             1'b0, 1'b1, 1'b0, 32'd1, 32'd2);
        tick();
        clear_inputs();
        push(13, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd3);
        tick();

        // Load-use, then DMEM busy for 4 cycles in the middle of the stall
        set_load(1'b1, 5'd3, 5'd3, 5'd0, 2'b01);
        set_wb(1'b1, 5'd12, 32'hC0FFEE);
        push(20, 1'b0, 64'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'd1, 32'd3);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_load(1'b0, 5'd0, 5'd3, 5'd0, 2'b01);
            set_wb(1'b1, 5'd10, 32'hBAD);
            set_ex(5'd12, 32'h12, 5'd10, 32'h10);
            b1.i_DMEM_busy = 1'b1;
            push(21 + i, 1'b1, {32'hBAD, 32'hC0FFEE}, 4'b1011,
                 1'b0, 1'b0, 1'b1, 32'd2, 32'd4);
            tick();
        end
        b1.i_DMEM_busy = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        push(25, 1'b1, {32'h10, 32'hC0FFEE}, 4'b0011, 1'b0, 1'b1, 1'b0, 32'd2, 32'd4);
        tick();
        push(26, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 32'd2, 32'd5);
        tick();
        clear_inputs();
        push(27, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd6);
        tick();

        // Hit arriving during freeze is taken once freeze releases
        set_load(1'b1, 5'd3, 5'd3, 5'd0, 2'b01);
        b1.i_DMEM_busy = 1'b1;
        push(30, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 32'd2, 32'd6);
        tick();
        b1.i_DMEM_busy = 1'b0;
        set_wb(1'b1, 5'd14, 32'h1414);
        push(31, 1'b0, 64'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'd2, 32'd6);
        tick();

        // Reset while the LOAD_BUBBLES=3 unit is in STALL with cnt=1
        rst = 1'b1;
        set_load(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
        push(32, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 32'd3, 32'd7);
        tick();
        rst = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        set_ex(5'd14, 32'h41, 5'd0, 32'h0);
        push(33, 1'b1, {32'h0, 32'h41}, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        set_load(1'b1, 5'd3, 5'd3, 5'd0, 2'b01);
        push(34, 1'b0, 64'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        clear_inputs();
        push(35, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1);
        tick();

        repeat (2) tick();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
